// File: rtl/block_sync_pkg.sv
// Shared types and constants for the 64b/66b block-lock stage.
// Header validity helper lives here so the bench-facing rules stay in one place.
package block_sync_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    SLIPWAIT = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int VALID_CNT_D   = 64;
  localparam int WINDOW_D      = 64;
  localparam int INVALID_CNT_D = 16;
  localparam int SLIP_WAIT_D   = 4;

  function automatic logic sh_valid(
    input logic [1:0] hdr
  );
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/sat_counter_16.sv
// 16-bit saturating event counter with synchronous clear.
// Holds at 16'hFFFF once reached; only i_clr brings it back to zero.
module sat_counter_16 (
  input  logic        clk,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_cnt <= 16'h0000;
    else if (i_en && (r_cnt != 16'hFFFF))
      r_cnt <= r_cnt + 16'h0001;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/block_sync_66.sv
// 64b/66b block-lock: hunts sync headers via gearbox bitslip, monitors lock.
// Define BLOCK_SYNC_STATS_EN to enable the saturating bad_hdr_cnt statistic.
module block_sync_66
  import block_sync_pkg::*;
#(
  parameter int VALID_CNT   = VALID_CNT_D,
  parameter int WINDOW      = WINDOW_D,
  parameter int INVALID_CNT = INVALID_CNT_D,
  parameter int SLIP_WAIT   = SLIP_WAIT_D
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic [65:0] din,
  input  logic        din_valid,
  output logic        slip,
  output logic        block_lock,
  output logic [63:0] dout,
  output logic [1:0]  dout_hdr,
  output logic        dout_valid,
  output logic [15:0] bad_hdr_cnt
);

  localparam int MX = (VALID_CNT > WINDOW) ? VALID_CNT : WINDOW;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO = '0;

  state_e        r_state, w_nstate;
  logic [CW-1:0] r_sh_cnt, w_sh_nxt;
  logic [CW-1:0] r_win_cnt, w_win_nxt;
  logic [CW-1:0] r_inv_cnt, w_inv_nxt;
  logic [CW-1:0] r_wait_cnt, w_wait_nxt;
  logic          r_slip, w_slip_nxt;
  logic [63:0]   r_dout;
  logic [1:0]    r_hdr;
  logic          r_dv;

  logic          w_hv;
  logic [CW-1:0] w_sh_inc, w_win_inc, w_inv_inc, w_wait_inc;

  assign w_hv       = sh_valid(din[1:0]);
  assign w_sh_inc   = r_sh_cnt + ONE;
  assign w_win_inc  = r_win_cnt + ONE;
  assign w_inv_inc  = r_inv_cnt + {{(CW-1){1'b0}}, ~w_hv};
  assign w_wait_inc = r_wait_cnt + ONE;

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state    <= HUNT;
      r_sh_cnt   <= ZERO;
      r_win_cnt  <= ZERO;
      r_inv_cnt  <= ZERO;
      r_wait_cnt <= ZERO;
      r_slip     <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_sh_cnt   <= w_sh_nxt;
      r_win_cnt  <= w_win_nxt;
      r_inv_cnt  <= w_inv_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_slip     <= w_slip_nxt;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_sh_nxt   = r_sh_cnt;
    w_win_nxt  = r_win_cnt;
    w_inv_nxt  = r_inv_cnt;
    w_wait_nxt = r_wait_cnt;
    w_slip_nxt = 1'b0;
    if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (!w_hv) begin
            w_slip_nxt = 1'b1;
            w_sh_nxt   = ZERO;
            w_nstate   = SLIPWAIT;
          end else if (w_sh_inc == CW'(VALID_CNT)) begin
            w_sh_nxt = ZERO;
            w_nstate = LOCKED;
          end else begin
            w_sh_nxt = w_sh_inc;
          end
        end
        SLIPWAIT: begin
          if (w_wait_inc == CW'(SLIP_WAIT)) begin
            w_wait_nxt = ZERO;
            w_sh_nxt   = ZERO;
            w_nstate   = HUNT;
          end else begin
            w_wait_nxt = w_wait_inc;
          end
        end
        LOCKED: begin
          // Loss of lock wins over the window-end reset on the same word.
          if (w_inv_inc == CW'(INVALID_CNT)) begin
            w_slip_nxt = 1'b1;
            w_win_nxt  = ZERO;
            w_inv_nxt  = ZERO;
            w_nstate   = SLIPWAIT;
          end else if (w_win_inc == CW'(WINDOW)) begin
            w_win_nxt = ZERO;
            w_inv_nxt = ZERO;
          end else begin
            w_win_nxt = w_win_inc;
            w_inv_nxt = w_inv_inc;
          end
        end
        default: w_nstate = HUNT;
      endcase
    end
  end

  always_comb begin
    block_lock = (r_state == LOCKED);
    slip       = r_slip;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_dout <= 64'h0;
      r_hdr  <= 2'b00;
      r_dv   <= 1'b0;
    end else begin
      r_dv <= din_valid & block_lock;
      if (din_valid) begin
        r_dout <= din[65:2];
        r_hdr  <= din[1:0];
      end
    end
  end

  assign dout       = r_dout;
  assign dout_hdr   = r_hdr;
  assign dout_valid = r_dv;

`ifdef BLOCK_SYNC_STATS_EN
  sat_counter_16 u_stats (
    .clk   (clk),
    .i_clr (sclr),
    .i_en  (din_valid & ~w_hv & (r_state != SLIPWAIT)),
    .o_cnt (bad_hdr_cnt)
  );
`else
  assign bad_hdr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_block_sync_66.sv
// Bench for block_sync_66: directed scenarios plus random stream
// checked cycle by cycle against a window/queue based lock model.
module tb_block_sync_66;

  logic        clk = 1'b0;
  logic        sclr;
  logic [65:0] din;
  logic        din_valid;
  logic        slip;
  logic        block_lock;
  logic [63:0] dout;
  logic [1:0]  dout_hdr;
  logic        dout_valid;
  logic [15:0] bad_hdr_cnt;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  block_sync_66 dut (
    .clk         (clk),
    .sclr        (sclr),
    .din         (din),
    .din_valid   (din_valid),
    .slip        (slip),
    .block_lock  (block_lock),
    .dout        (dout),
    .dout_hdr    (dout_hdr),
    .dout_valid  (dout_valid),
    .bad_hdr_cnt (bad_hdr_cnt)
  );

  // Reference model state
  bit          m_lock;
  int          m_run;
  int          m_ignore;
  bit          win_q[$];
  logic [63:0] e_dout;
  logic [1:0]  e_hdr;
  bit          e_dv;
  bit          e_slip;
  int          e_stat;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic int win_bad_sum();
    int s = 0;
    foreach (win_q[i]) s += int'(win_q[i]);
    return s;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_run = 0; m_ignore = 0; win_q.delete();
    e_dout = '0; e_hdr = '0; e_dv = 0; e_slip = 0; e_stat = 0;
  endtask

  task automatic model_step(input bit rst, input bit dv,
                            input logic [65:0] d);
    bit bad;
    e_slip = 0;
    if (rst) begin
      model_reset();
      return;
    end
    e_dv = dv && m_lock;
    if (!dv) return;
    e_dout = d[65:2];
    e_hdr  = d[1:0];
    bad = !(d[1:0] == 2'b01 || d[1:0] == 2'b10);
`ifdef BLOCK_SYNC_STATS_EN
    if (bad && m_ignore == 0 && e_stat < 65535) e_stat++;
`endif
    if (m_ignore > 0) begin
      m_ignore--;
    end else if (!m_lock) begin
      if (bad) begin
        e_slip = 1; m_ignore = 4; m_run = 0;
      end else begin
        m_run++;
        if (m_run == 64) begin m_lock = 1; m_run = 0; end
      end
    end else begin
      win_q.push_back(bad);
      if (win_bad_sum() == 16) begin
        m_lock = 0; e_slip = 1; m_ignore = 4; win_q.delete();
      end else if (win_q.size() == 64) begin
        win_q.delete();
      end
    end
  endtask

  task automatic tick(input bit rst, input bit dv, input logic [1:0] h);
    logic [65:0] d;
    d = {$urandom(), $urandom(), h};
    sclr = rst; din_valid = dv; din = d;
    @(posedge clk);
    model_step(rst, dv, d);
    #1;
    chk("slip", 64'(slip), 64'(e_slip));
    chk("block_lock", 64'(block_lock), 64'(m_lock));
    chk("dout_valid", 64'(dout_valid), 64'(e_dv));
    chk("dout", dout, e_dout);
    chk("dout_hdr", 64'(dout_hdr), 64'(e_hdr));
    chk("bad_hdr_cnt", 64'(bad_hdr_cnt), 64'(e_stat));
  endtask

  task automatic word(input logic [1:0] h);
    tick(0, 1, h);
  endtask

  task automatic good_words(input int n);
    for (int i = 0; i < n; i++) word((i % 2 == 0) ? 2'b01 : 2'b10);
  endtask

  function automatic logic [1:0] rnd_bad();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  initial begin
    int pct;
    sclr = 1'b1; din_valid = 1'b0; din = '0;
    model_reset();
    tick(1, 0, 2'b00);
    tick(1, 1, 2'b11);
    chk("reset_lock", 64'(block_lock), 64'd0);

    // Aligned stream: lock after 64th word
    good_words(63);
    chk("prelock", 64'(block_lock), 64'd0);
    good_words(1);
    chk("lock64", 64'(block_lock), 64'd1);
    good_words(6);

    // Hunt with a bad header on word 10, ignored words, relock
    tick(1, 0, 2'b00);
    good_words(9);
    word(2'b11);
    chk("slip_pulse", 64'(slip), 64'd1);
    for (int i = 0; i < 4; i++) word(rnd_bad());
    good_words(64);
    chk("relock", 64'(block_lock), 64'd1);

    // 15 bad in one window stays locked; 16 loses lock
    for (int i = 0; i < 64; i++) word((i % 4 == 0 && i < 60) ? 2'b00 : 2'b01);
    chk("hold15", 64'(block_lock), 64'd1);
    for (int i = 0; i < 31; i++) word((i % 2 == 0) ? 2'b11 : 2'b10);
    chk("loss16", 64'(block_lock), 64'd0);
    for (int i = 0; i < 4; i++) word(2'b01);
    good_words(64);

    // 16th bad on window-end word
    for (int i = 0; i < 64; i++)
      word((i < 15 || i == 63) ? 2'b00 : 2'b10);
    chk("endloss", 64'(block_lock), 64'd0);

    // sclr during SLIPWAIT and mid-hunt, then gapped relock
    word(2'b00);
    word(2'b01);
    tick(1, 1, 2'b01);
    good_words(40);
    tick(1, 1, 2'b01);
    for (int i = 0; i < 64; i++) begin
      word(2'b01);
      if (i % 8 == 3) for (int g = 0; g < 3; g++) tick(0, 0, 2'b00);
    end
    chk("gaplock", 64'(block_lock), 64'd1);

`ifdef BLOCK_SYNC_STATS_EN
    tick(1, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      word(2'b00);
      for (int j = 0; j < 4; j++) word(2'b01);
    end
    chk("stat5", 64'(bad_hdr_cnt), 64'd5);
    force dut.u_stats.r_cnt = 16'hFFFE;
    #1;
    release dut.u_stats.r_cnt;
    e_stat = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      word(2'b11);
      for (int j = 0; j < 4; j++) word(2'b10);
    end
    chk("statsat", 64'(bad_hdr_cnt), 64'hFFFF);
`endif

    // Random stress
    tick(1, 0, 2'b00);
    for (int s = 0; s < 12; s++) begin
      pct = (s % 4 == 0) ? 0 : (s % 4 == 1) ? 2 : (s % 4 == 2) ? 10 : 30;
      for (int i = 0; i < 200; i++) begin
        tick($urandom_range(0, 999) < 3,
             $urandom_range(0, 99) < 80,
             ($urandom_range(0, 99) < pct) ? rnd_bad() :
             (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10));
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
